// File: rtl/dmem_bus_pkg.sv
// dmem_bus_pkg: shared types and constants for the data-memory bus bridge
package dmem_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;
  localparam logic [3:0] BE_ALL = 4'hF;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/dmem_bus_bridge_if.sv
// dmem_bus_bridge_if: core memory-stage port plus req/ack slave bus, seen from the bridge (master) or its environment (slave)
interface dmem_bus_bridge_if #(parameter int AW = 32);
  logic          cpu_en;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [31:0]   bus_rdata;
  logic          bus_err;
  modport master (
    input  cpu_en, cpu_be, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    output cpu_rdata, cpu_stall, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err
  );
  modport slave (
    output cpu_en, cpu_be, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    input  cpu_rdata, cpu_stall, bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: counts request cycles and flags the last one allowed before abort
module bus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= clear_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  // counter holds the number of completed request cycles, so this is the TIMEOUT-th one
  assign expired_o = en_i && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns a single-cycle core data access into a req/ack bus transaction with stall and timeout
module dmem_bus_bridge
  import dmem_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = 32
) (
  input logic             clk,
  input logic             rst,
  dmem_bus_bridge_if.master bus
);
  state_t        state_q;
  logic          req_q, we_q, err_q, expired;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, rdata_q;
  logic          accept;
  assign accept = state_q == ST_IDLE && bus.cpu_en;
  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk), .rst(rst), .clear_i(accept), .en_i(state_q == ST_REQ), .expired_o(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (bus.cpu_en) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            we_q    <= |bus.cpu_be;
            be_q    <= |bus.cpu_be ? bus.cpu_be : BE_ALL;
            addr_q  <= {bus.cpu_addr[AW-1:2], 2'b00};
            wdata_q <= bus.cpu_wdata;
          end
        ST_REQ:
          if (bus.bus_ack) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            if (!we_q) rdata_q <= bus.bus_rdata;
          end else if (expired) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  assign bus.cpu_stall = accept || state_q == ST_REQ;
  assign bus.cpu_rdata = rdata_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_err   = err_q;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed scenario tests for the data-memory bus bridge with TIMEOUT = 8
module tb_dmem_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  dmem_bus_bridge_if #(.AW(32)) bus ();
  dmem_bus_bridge #(.TIMEOUT(8), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          stall_n, req_n, first_c, last_c;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        a_we, stable, hung;

  // Drives one access from an IDLE cycle and returns in the DONE cycle, recording what the bus showed.
  task automatic run_access(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_after, input logic [31:0] ack_data);
    @(negedge clk);
    bus.cpu_en = 1'b1; bus.cpu_be = be; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    #1;
    stall_n = bus.cpu_stall ? 1 : 0;
    req_n = 0; first_c = 0; last_c = 0; stable = 1'b1; hung = 1'b1;
    a_addr = '0; a_wdata = '0; a_be = '0; a_we = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.cpu_en = 1'b0; bus.bus_ack = 1'b0;
      #1;
      if (bus.bus_req) begin
        if (req_n == 0) begin
          first_c = cyc; a_addr = bus.bus_addr; a_be = bus.bus_be; a_we = bus.bus_we; a_wdata = bus.bus_wdata;
        end else if (a_addr !== bus.bus_addr || a_be !== bus.bus_be || a_we !== bus.bus_we || a_wdata !== bus.bus_wdata)
          stable = 1'b0;
        req_n++;
        last_c = cyc;
      end
      if (!bus.cpu_stall) begin
        hung = 1'b0;
        break;
      end
      stall_n++;
      if (req_n == ack_after) begin
        bus.bus_ack = 1'b1; bus.bus_rdata = ack_data;
      end
    end
    bus.bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.bus_req); end
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.bus_err); end
    n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.cpu_rdata); end
    n_cmp++; if ({bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata} !== 69'h0) begin n_fail++;
      $display("FAIL reset_bus got we=%b be=%h addr=%h wd=%h want all 0", bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle got %b want 0", bus.cpu_stall); end
    bus.cpu_en = 1'b1; #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_en got %b want 1", bus.cpu_stall); end
    bus.cpu_en = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_zero_wait_read();
    run_access(4'h0, 32'h103, 32'h0, 1, 32'hDEADBEEF);
    n_cmp++; if (hung !== 1'b0) begin n_fail++; $display("FAIL zw_done got hung=%b want 0", hung); end
    n_cmp++; if (a_addr !== 32'h100) begin n_fail++; $display("FAIL zw_addr got %h want 00000100", a_addr); end
    n_cmp++; if (a_be !== 4'hF) begin n_fail++; $display("FAIL zw_be got %h want f", a_be); end
    n_cmp++; if (a_we !== 1'b0) begin n_fail++; $display("FAIL zw_we got %b want 0", a_we); end
    n_cmp++; if (stall_n !== 2) begin n_fail++; $display("FAIL zw_stall_cycles got %0d want 2", stall_n); end
    n_cmp++; if (req_n !== 1) begin n_fail++; $display("FAIL zw_req_cycles got %0d want 1", req_n); end
    n_cmp++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zw_rdata got %h want deadbeef", bus.cpu_rdata); end
  endtask

  task automatic test_wait_write();
    run_access(4'b0100, 32'h42, 32'h00AB0000, 5, 32'hFFFFFFFF);
    n_cmp++; if (a_we !== 1'b1) begin n_fail++; $display("FAIL wr_we got %b want 1", a_we); end
    n_cmp++; if (a_be !== 4'b0100) begin n_fail++; $display("FAIL wr_be got %b want 0100", a_be); end
    n_cmp++; if (a_addr !== 32'h40) begin n_fail++; $display("FAIL wr_addr got %h want 00000040", a_addr); end
    n_cmp++; if (a_wdata !== 32'h00AB0000) begin n_fail++; $display("FAIL wr_wdata got %h want 00ab0000", a_wdata); end
    n_cmp++; if (req_n !== 5) begin n_fail++; $display("FAIL wr_req_cycles got %0d want 5", req_n); end
    n_cmp++; if (stall_n !== 6) begin n_fail++; $display("FAIL wr_stall_cycles got %0d want 6", stall_n); end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL wr_bus_stable got %b want 1", stable); end
    n_cmp++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rdata_kept got %h want deadbeef", bus.cpu_rdata); end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h1234;
    @(negedge clk);
    bus.bus_ack = 1'b0; #1;
    n_cmp++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL sp_req got %b want 0", bus.bus_req); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL sp_stall got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sp_rdata got %h want deadbeef", bus.cpu_rdata); end
  endtask

  task automatic test_back_to_back();
    int last1;
    run_access(4'h0, 32'h200, 32'h0, 1, 32'h0BADF00D);
    last1 = last_c;
    n_cmp++; if (a_addr !== 32'h200) begin n_fail++; $display("FAIL b2b_addr1 got %h want 00000200", a_addr); end
    n_cmp++; if (bus.cpu_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_rdata1 got %h want 0badf00d", bus.cpu_rdata); end
    run_access(4'hF, 32'h204, 32'h11223344, 1, 32'h99999999);
    n_cmp++; if (a_addr !== 32'h204 || a_we !== 1'b1) begin n_fail++; $display("FAIL b2b_addr2 got %h we=%b want 00000204 we=1", a_addr, a_we); end
    n_cmp++; if (first_c - last1 - 1 !== 2) begin n_fail++; $display("FAIL b2b_gap got %0d want 2", first_c - last1 - 1); end
    n_cmp++; if (bus.cpu_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL b2b_rdata2 got %h want 0badf00d", bus.cpu_rdata); end
  endtask

  task automatic test_timeout();
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_before got %b want 0", bus.bus_err); end
    run_access(4'h0, 32'h300, 32'h0, 0, 32'h0);
    n_cmp++; if (req_n !== 8) begin n_fail++; $display("FAIL to_req_cycles got %0d want 8", req_n); end
    n_cmp++; if (stall_n !== 9) begin n_fail++; $display("FAIL to_stall_cycles got %0d want 9", stall_n); end
    n_cmp++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", bus.bus_err); end
    n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata got %h want 0", bus.cpu_rdata); end
    run_access(4'h0, 32'h308, 32'h0, 3, 32'h000055AA);
    n_cmp++; if (req_n !== 3 || hung !== 1'b0) begin n_fail++; $display("FAIL to_next_req got %0d hung=%b want 3 hung=0", req_n, hung); end
    n_cmp++; if (bus.cpu_rdata !== 32'h000055AA) begin n_fail++; $display("FAIL to_next_rdata got %h want 000055aa", bus.cpu_rdata); end
    n_cmp++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got %b want 1", bus.bus_err); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cpu_en = 1'b1; bus.cpu_be = 4'hF; bus.cpu_addr = 32'h404; bus.cpu_wdata = 32'hA5A5A5A5;
    @(negedge clk); bus.cpu_en = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_before got %b want 1", bus.bus_req); end
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h77777777;
    rst = 1'b0; #1;
    n_cmp++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL rm_req got %b want 0", bus.bus_req); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL rm_err got %b want 0", bus.bus_err); end
    n_cmp++; if ({bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata, bus.cpu_rdata} !== 101'h0) begin n_fail++;
      $display("FAIL rm_outputs got we=%b be=%h addr=%h wd=%h rd=%h want all 0", bus.bus_we, bus.bus_be, bus.bus_addr, bus.bus_wdata, bus.cpu_rdata); end
    @(negedge clk);
    bus.bus_ack = 1'b0; rst = 1'b1;
    run_access(4'h0, 32'h500, 32'h0, 2, 32'hCAFEF00D);
    n_cmp++; if (req_n !== 2 || a_addr !== 32'h500) begin n_fail++; $display("FAIL rm_after got req=%0d addr=%h want 2 00000500", req_n, a_addr); end
    n_cmp++; if (bus.cpu_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rm_after_rdata got %h want cafef00d", bus.cpu_rdata); end
  endtask

  initial begin
    bus.cpu_en = 1'b0; bus.cpu_be = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_spurious_ack();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
